rv32_regfile: RTL and testbench

//   RV32I integer register file x0..x31 for the core's decode/execute stage.
//   - Two combinational read ports (rs1, rs2) and one clocked write port (rd).
//   - x0 is hard-wired to zero.
//   - Write-first bypass: a read of the register being written in the same

---
 rtl/rv32_pkg.sv | 14 +
 rtl/rv32_regfile_rdport.sv | 35 +++
 rtl/rv32_regfile.sv | 71 +++++++
 tb/tb_rv32_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared constants and types for the RV32I integer register file.
// Address and data widths are fixed here so every user sees one definition.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rv32_regfile_rdport.sv
// One combinational read port: x0 zero-check, optional write-first bypass
// from the write port, otherwise the stored register value.
module rv32_regfile_rdport
  import rv32_pkg::*;
#(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int NREGS  = rv32_pkg::NREGS,
  parameter int AW     = rv32_pkg::AW,
  parameter int BYPASS = 1
) (
  input  logic                       i_en,
  input  logic [AW-1:0]              i_addr,
  input  logic [AW-1:0]              i_rd_address,
  input  logic [XLEN-1:0]            i_rd_value,
  input  logic [NREGS-1:0][XLEN-1:0] i_regs,
  output logic [XLEN-1:0]            o_value
);

  logic            w_is_zero;
  logic            w_hit;
  logic [XLEN-1:0] w_stored;

  assign w_is_zero = (i_addr == AW'(REG_ZERO));
  assign w_hit     = (BYPASS != 0) && (i_addr == i_rd_address);
  assign w_stored  = i_regs[i_addr];

  // While reset is held the port reads zero, even if a write is presented.
  always_comb begin
    o_value = '0;
    if (i_en && !w_is_zero) begin
      o_value = w_hit ? i_rd_value : w_stored;
    end
  end

endmodule

// File: rtl/rv32_regfile.sv
// RV32I integer register file: x1..x31 storage, one clocked write port and
// two combinational read ports; x0 has no storage and always reads zero.
module rv32_regfile
  import rv32_pkg::*;
#(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int NREGS  = rv32_pkg::NREGS,
  parameter int AW     = rv32_pkg::AW,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_address,
  input  logic [AW-1:0]   rs2_address,
  input  logic [AW-1:0]   rd_address,
  input  logic [XLEN-1:0] rd_value,
  output logic [XLEN-1:0] rs1_value_o,
  output logic [XLEN-1:0] rs2_value_o
);

  logic [XLEN-1:0]            r_mem [1:NREGS-1];
  logic [NREGS-1:0][XLEN-1:0] w_regs;
  logic                       w_wr_en;

  // Unknown or zero rd_address never enables a write.
  assign w_wr_en   = (rd_address != AW'(REG_ZERO));
  assign w_regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_mem[gi] <= '0;
        end else if (w_wr_en && (rd_address == AW'(gi))) begin
          r_mem[gi] <= rd_value;
        end
      end
      assign w_regs[gi] = r_mem[gi];
    end
  endgenerate

  rv32_regfile_rdport #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rs1 (
    .i_en         (reset_n),
    .i_addr       (rs1_address),
    .i_rd_address (rd_address),
    .i_rd_value   (rd_value),
    .i_regs       (w_regs),
    .o_value      (rs1_value_o)
  );

  rv32_regfile_rdport #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rs2 (
    .i_en         (reset_n),
    .i_addr       (rs2_address),
    .i_rd_address (rd_address),
    .i_rd_value   (rd_value),
    .i_regs       (w_regs),
    .o_value      (rs2_value_o)
  );

endmodule

// File: tb/tb_rv32_regfile.sv
// Directed bench for rv32_regfile: a bypassing instance and a BYPASS=0
// instance share all inputs; each scenario task checks its own results.
module tb_rv32_regfile;
  import rv32_pkg::*;

  logic      clk = 1'b0;
  logic      reset_n;
  reg_addr_t rs1_address, rs2_address, rd_address;
  xlen_t     rd_value;
  xlen_t     rs1_value_o, rs2_value_o;
  xlen_t     nb_rs1_value, nb_rs2_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_regfile #(.BYPASS(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs1_address (rs1_address),
    .rs2_address (rs2_address),
    .rd_address  (rd_address),
    .rd_value    (rd_value),
    .rs1_value_o (rs1_value_o),
    .rs2_value_o (rs2_value_o)
  );

  rv32_regfile #(.BYPASS(0)) dut_nb (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs1_address (rs1_address),
    .rs2_address (rs2_address),
    .rd_address  (rd_address),
    .rd_value    (rd_value),
    .rs1_value_o (nb_rs1_value),
    .rs2_value_o (nb_rs2_value)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rd_address  = reg_addr_t'($urandom_range(1, 31));
      rd_value    = xlen_t'($urandom);
      rs1_address = rd_address;
      rs2_address = reg_addr_t'($urandom_range(1, 31));
      #2;
      checks++;
      if (rs1_value_o !== 32'd0 || rs2_value_o !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold rd=%0d rs1=%0h rs2=%0h required 0", rd_address, rs1_value_o, rs2_value_o);
      end
    end
    @(negedge clk);
    rd_address = '0;
    rd_value   = '0;
    reset_n    = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rs1_address = reg_addr_t'(i);
      rs2_address = reg_addr_t'(32 - i);
      #2;
      checks++;
      if (rs1_value_o !== 32'd0 || rs2_value_o !== 32'd0) begin
        errors++;
        $display("FAIL reset_clear x%0d rs1=%0h rs2=%0h required 0", i, rs1_value_o, rs2_value_o);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    @(negedge clk);
    rd_address  = 5'd4;
    rd_value    = 32'd546;
    rs1_address = 5'd4;
    rs2_address = 5'd4;
    #2;
    checks++;
    if (rs1_value_o !== 32'd546 || rs2_value_o !== 32'd546) begin
      errors++;
      $display("FAIL bypass_x4 rs1=%0d rs2=%0d required 546", rs1_value_o, rs2_value_o);
    end
    @(posedge clk);
    #1 rd_address = '0;
    #1;
    checks++;
    if (rs1_value_o !== 32'd546 || rs2_value_o !== 32'd546) begin
      errors++;
      $display("FAIL stored_x4 rs1=%0d rs2=%0d required 546", rs1_value_o, rs2_value_o);
    end
    $display("test_write_read rd=4 value=546");
  endtask

  task automatic test_x0();
    @(negedge clk);
    rd_address  = 5'd0;
    rd_value    = 32'd654;
    rs1_address = 5'd0;
    rs2_address = 5'd0;
    #2;
    checks++;
    if (rs1_value_o !== 32'd0 || rs2_value_o !== 32'd0) begin
      errors++;
      $display("FAIL x0_pre rs1=%0d rs2=%0d required 0", rs1_value_o, rs2_value_o);
    end
    @(posedge clk);
    #2;
    checks++;
    if (rs1_value_o !== 32'd0 || rs2_value_o !== 32'd0) begin
      errors++;
      $display("FAIL x0_post rs1=%0d rs2=%0d required 0", rs1_value_o, rs2_value_o);
    end
    rs1_address = 5'd4;
    rs2_address = 5'd4;
    #1;
    checks++;
    if (rs1_value_o !== 32'd546 || rs2_value_o !== 32'd546) begin
      errors++;
      $display("FAIL x4_kept rs1=%0d rs2=%0d required 546", rs1_value_o, rs2_value_o);
    end
    $display("test_x0 rd=0 value=654");
  endtask

  task automatic test_sweep();
    xlen_t exp1, exp2;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rd_address = reg_addr_t'(i);
      rd_value   = xlen_t'((i + 1) * 12);
    end
    @(negedge clk);
    rd_address = '0;
    rd_value   = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1_address = reg_addr_t'(i);
      rs2_address = reg_addr_t'(31 - i);
      exp1 = (i == 0) ? 32'd0 : xlen_t'((i + 1) * 12);
      exp2 = (i == 31) ? 32'd0 : xlen_t'((32 - i) * 12);
      #2;
      checks++;
      if (rs1_value_o !== exp1 || rs2_value_o !== exp2) begin
        errors++;
        $display("FAIL sweep x%0d/x%0d rs1=%0d rs2=%0d required %0d/%0d", i, 31 - i, rs1_value_o, rs2_value_o, exp1, exp2);
      end
    end
    $display("test_sweep done");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rs1_address = 5'd5;
    rs2_address = 5'd31;
    #2;
    checks++;
    if (rs1_value_o !== 32'd72 || rs2_value_o !== 32'd384) begin
      errors++;
      $display("FAIL pre_async rs1=%0d rs2=%0d required 72/384", rs1_value_o, rs2_value_o);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rs1_value_o !== 32'd0 || rs2_value_o !== 32'd0 || nb_rs1_value !== 32'd0) begin
      errors++;
      $display("FAIL async_drop rs1=%0d rs2=%0d nb=%0d required 0", rs1_value_o, rs2_value_o, nb_rs1_value);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i < 32; i += 3) begin
      @(negedge clk);
      rs1_address = reg_addr_t'(i);
      rs2_address = reg_addr_t'(i + 1);
      #2;
      checks++;
      if (rs1_value_o !== 32'd0 || rs2_value_o !== 32'd0) begin
        errors++;
        $display("FAIL async_clear x%0d rs1=%0d rs2=%0d required 0", i, rs1_value_o, rs2_value_o);
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    rd_address  = 5'd7;
    rd_value    = 32'd99;
    rs1_address = 5'd7;
    rs2_address = 5'd7;
    #2;
    checks++;
    if (nb_rs1_value !== 32'd0) begin
      errors++;
      $display("FAIL nobyp_pre got=%0d required 0", nb_rs1_value);
    end
    checks++;
    if (rs1_value_o !== 32'd99) begin
      errors++;
      $display("FAIL byp_pre got=%0d required 99", rs1_value_o);
    end
    @(posedge clk);
    #1 rd_address = '0;
    #1;
    checks++;
    if (nb_rs1_value !== 32'd99 || nb_rs2_value !== 32'd99) begin
      errors++;
      $display("FAIL nobyp_post rs1=%0d rs2=%0d required 99", nb_rs1_value, nb_rs2_value);
    end
    $display("test_no_bypass rd=7 value=99");
  endtask

  initial begin
    reset_n     = 1'b0;
    rs1_address = '0;
    rs2_address = '0;
    rd_address  = '0;
    rd_value    = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_sweep();
    test_async_reset();
    test_no_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
